// File: rtl/alu_mdu.sv
// ---------------------------------------------------------------------------
// alu_mdu : registered RV32I ALU + RV32M multiply/divide unit for the EX stage
//
// Base ALU ops and divide special cases finish one cycle after accept.
// MUL*/DIV*/REM* go through an iterative engine: shift-add for multiply,
// restoring shift-subtract for divide. Both work on operand magnitudes, and
// the sign is fixed up on the last iteration. From accept to out_valid takes
// XLEN+1 cycles.
//
// Optional build macro: ALU_MDU_FAST_MUL_EN
//   defined   : func 10-13 use a combinational multiplier and finish in 1 cycle
//   undefined : multiply shares the iterative engine and no multiplier is built
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   operation handshake; a, b, func sampled on accept
//   out_valid/out_ready result handshake; out, out_illegal held while waiting
// ---------------------------------------------------------------------------
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      func,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            out_illegal
);

    localparam logic [4:0] F_ADD    = 5'd0;
    localparam logic [4:0] F_SUB    = 5'd1;
    localparam logic [4:0] F_AND    = 5'd2;
    localparam logic [4:0] F_OR     = 5'd3;
    localparam logic [4:0] F_XOR    = 5'd4;
    localparam logic [4:0] F_SLT    = 5'd5;
    localparam logic [4:0] F_SLTU   = 5'd6;
    localparam logic [4:0] F_SLL    = 5'd7;
    localparam logic [4:0] F_SRL    = 5'd8;
    localparam logic [4:0] F_SRA    = 5'd9;
    localparam logic [4:0] F_MUL    = 5'd10;
    localparam logic [4:0] F_MULH   = 5'd11;
    localparam logic [4:0] F_MULHSU = 5'd12;
    localparam logic [4:0] F_MULHU  = 5'd13;
    localparam logic [4:0] F_DIV    = 5'd14;
    localparam logic [4:0] F_DIVU   = 5'd15;
    localparam logic [4:0] F_REM    = 5'd16;
    localparam logic [4:0] F_REMU   = 5'd17;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;     // partial product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiplier bits / dividend-then-quotient bits
    logic [XLEN-1:0] mc_q, mc_d;     // multiplicand or divisor magnitude
    logic            neg_q, neg_d;   // negate the selected result at completion
    logic            sel_q, sel_d;   // mul: take high half; div: take remainder
    logic            isdiv_q, isdiv_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            ill_q, ill_d;

    logic accept;

    assign in_ready    = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == S_DONE);
    assign out         = out_q;
    assign out_illegal = ill_q;

    // ---------------------------------------------------------------- decode
    logic            is_mul, is_div, is_ill;
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, quick;

    always_comb begin
        is_mul   = (func >= F_MUL) && (func <= F_MULHU);
        is_div   = (func >= F_DIV) && (func <= F_REMU);
        is_ill   = (func > F_REMU);
        a_sgn    = (func == F_MULH) || (func == F_MULHSU) || (func == F_DIV) || (func == F_REM);
        b_sgn    = (func == F_MULH) || (func == F_DIV) || (func == F_REM);
        a_neg    = a_sgn && a[XLEN-1];
        b_neg    = b_sgn && b[XLEN-1];
        a_mag    = a_neg ? (~a + 1'b1) : a;
        b_mag    = b_neg ? (~b + 1'b1) : b;
        div_zero = is_div && (b == '0);
        div_ovf  = ((func == F_DIV) || (func == F_REM)) && (a == MOST_NEG) && (b == '1);
`ifdef ALU_MDU_FAST_MUL_EN
        quick    = !is_div || div_zero || div_ovf;
`else
        quick    = !(is_mul || is_div) || div_zero || div_ovf;
`endif
    end

    // ------------------------------------------------------- one-cycle path
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res, quick_res;

    assign shamt = b[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (func)
            F_ADD:   base_res = a + b;
            F_SUB:   base_res = a - b;
            F_AND:   base_res = a & b;
            F_OR:    base_res = a | b;
            F_XOR:   base_res = a ^ b;
            F_SLT:   base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLTU:  base_res = {{(XLEN-1){1'b0}}, (a < b)};
            F_SLL:   base_res = a << shamt;
            F_SRL:   base_res = a >> shamt;
            F_SRA:   base_res = $unsigned($signed(a) >>> shamt);
            default: base_res = '0;
        endcase
    end

`ifdef ALU_MDU_FAST_MUL_EN
    // One extra top bit per operand carries the signedness, so a single
    // signed multiplier covers all four variants.
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fp;
    logic [XLEN-1:0]          fast_res;

    always_comb begin
        fa       = $signed({a_sgn && a[XLEN-1], a});
        fb       = $signed({b_sgn && b[XLEN-1], b});
        fp       = fa * fb;
        fast_res = (func == F_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        quick_res = base_res;
        if (is_ill) begin
            quick_res = '0;
        end else if (div_zero) begin
            quick_res = ((func == F_DIV) || (func == F_DIVU)) ? '1 : a;
        end else if (div_ovf) begin
            quick_res = (func == F_DIV) ? a : '0;
`ifdef ALU_MDU_FAST_MUL_EN
        end else if (is_mul) begin
            quick_res = fast_res;
`endif
        end
    end

    // ------------------------------------------------------ iterative engine
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   it_hi, it_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   dv, iter_res;

    always_comb begin
        // Multiply: add the multiplicand if the current multiplier bit is set,
        // then shift {carry, hi, lo} right by one.
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
        // Divide: shift the next dividend bit into the remainder and subtract
        // the divisor when it fits. The difference always fits in XLEN bits.
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, mc_q});
        div_diff = div_sh[XLEN-1:0] - mc_q;

        if (isdiv_q) begin
            it_hi = div_ge ? div_diff : div_sh[XLEN-1:0];
            it_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        prod   = {it_hi, it_lo};
        prod_s = neg_q ? (~prod + 1'b1) : prod;
        dv     = sel_q ? it_hi : it_lo;

        if (isdiv_q) iter_res = neg_q ? (~dv + 1'b1) : dv;
        else         iter_res = sel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mc_d    = mc_q;
        neg_d   = neg_q;
        sel_d   = sel_q;
        isdiv_d = isdiv_q;
        out_d   = out_q;
        ill_d   = ill_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE && out_ready) state_d = S_IDLE;
                if (accept) begin
                    if (quick) begin
                        out_d   = quick_res;
                        ill_d   = is_ill;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        hi_d    = '0;
                        isdiv_d = is_div;
                        if (is_div) begin
                            lo_d  = a_mag;
                            mc_d  = b_mag;
                            sel_d = (func == F_REM) || (func == F_REMU);
                            // Remainder follows the dividend; quotient sign is the xor.
                            neg_d = sel_d ? a_neg : (a_neg ^ b_neg);
                        end else begin
                            lo_d  = b_mag;
                            mc_d  = a_mag;
                            sel_d = (func != F_MUL);
                            neg_d = a_neg ^ b_neg;
                        end
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    out_d   = iter_res;
                    ill_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mc_q    <= '0;
            neg_q   <= 1'b0;
            sel_q   <= 1'b0;
            isdiv_q <= 1'b0;
            out_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mc_q    <= mc_d;
            neg_q   <= neg_d;
            sel_q   <= sel_d;
            isdiv_q <= isdiv_d;
            out_q   <= out_d;
            ill_q   <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed, table-driven bench for alu_mdu at XLEN=32, plus hand-written
// backpressure and reset-during-BUSY sequences.
module tb_alu_mdu;

    localparam int XLEN = 32;
`ifdef ALU_MDU_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = XLEN + 1;
`endif
    localparam int DL = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a, b;
    logic [4:0]      func;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;
    logic            out_illegal;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .func(func),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
        int          lat;
    } vec_t;

    localparam int NV = 26;
    vec_t vt [NV];

    // Offer one op at posedge+1, wait for out_valid and return result and latency.
    task automatic run_op(input logic [4:0] f, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] r, output logic ri, output int lat);
        logic busy_bad;
        chk("in_ready_at_offer", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; func = f; a = av; b = bv;
        @(posedge clk); #1;
        // Scramble operands: the block must have captured them already.
        in_valid = 1'b0; func = 5'd1; a = 32'hDEADBEEF; b = 32'h0;
        lat = 1;
        busy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
        if (lat > 1) chk("in_ready_low_busy", {31'b0, busy_bad}, 32'd0);
        r  = out;
        ri = out_illegal;
    endtask

    initial begin
        logic [31:0] r;
        logic        ri;
        int          lat;
        logic        bad;

        vt[0]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1};
        vt[1]  = '{5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1};
        vt[2]  = '{5'd2,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1};
        vt[3]  = '{5'd3,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1};
        vt[4]  = '{5'd4,  32'h0000FFFF, 32'h000000FF, 32'h0000FF00, 1'b0, 1};
        vt[5]  = '{5'd9,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1};
        vt[6]  = '{5'd5,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1};
        vt[7]  = '{5'd6,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1};
        vt[8]  = '{5'd7,  32'd1,        32'd36,       32'd16,       1'b0, 1};
        vt[9]  = '{5'd8,  32'h80000000, 32'd31,       32'd1,        1'b0, 1};
        vt[10] = '{5'd10, 32'd3,        32'hFFFFFFFB, 32'hFFFFFFF1, 1'b0, ML};
        vt[11] = '{5'd11, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, ML};
        vt[12] = '{5'd12, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, ML};
        vt[13] = '{5'd13, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, ML};
        vt[14] = '{5'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, DL};
        vt[15] = '{5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, DL};
        vt[16] = '{5'd14, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, DL};
        vt[17] = '{5'd16, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, DL};
        vt[18] = '{5'd15, 32'd100,      32'd7,        32'd14,       1'b0, DL};
        vt[19] = '{5'd17, 32'd100,      32'd7,        32'd2,        1'b0, DL};
        vt[20] = '{5'd15, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b0, 1};
        vt[21] = '{5'd16, 32'd5,        32'd0,        32'd5,        1'b0, 1};
        vt[22] = '{5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
        vt[23] = '{5'd16, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1};
        vt[24] = '{5'd20, 32'd12,       32'd34,       32'd0,        1'b1, 1};
        vt[25] = '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; func = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out", out, 32'd0);
        chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        rst_n = 1'b1;

        // Back-to-back sweep: each new offer lands on the edge the previous result drains.
        for (int i = 0; i < NV; i++) begin
            run_op(vt[i].f, vt[i].a, vt[i].b, r, ri, lat);
            chk($sformatf("vec%0d_out", i), r, vt[i].exp);
            chk($sformatf("vec%0d_illegal", i), {31'b0, ri}, {31'b0, vt[i].ill});
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
        end
        @(posedge clk); #1;
        chk("drain_idle", {31'b0, out_valid}, 32'd0);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        run_op(5'd0, 32'd1, 32'd2, r, ri, lat);
        chk("bp_first_out", r, 32'd3);
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (out !== 32'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        chk("bp_hold_stable", {31'b0, bad}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; func = 5'd1; a = 32'd10; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_same_edge_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_same_edge_out", out, 32'd7);
        @(posedge clk); #1;
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // Reset in the middle of a DIVU: nothing may come out afterwards.
        in_valid = 1'b1; func = 5'd15; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_out", out, 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) bad = 1'b1;
        end
        chk("midrst_no_result", {31'b0, bad}, 32'd0);

        // Block still usable after the abort.
        run_op(5'd14, 32'hFFFFFFF9, 32'd2, r, ri, lat);
        chk("post_rst_div", r, 32'hFFFFFFFD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
